// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: reverse double-dabble, one result bit per clock,
// valid/ready on both sides, with an error flag for non-BCD input digits.
module bcd_to_bin_seq #(
   parameter int unsigned DIGITS = 3,
   parameter int unsigned BIN_W  = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_DONE} state_e;

   state_e             state_q, state_d;
   logic [BCD_W-1:0]   bcd_sr_q, bcd_sr_d;
   logic [BIN_W-1:0]   bin_sr_q, bin_sr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic               err_q, err_d;

   logic               accept;
   logic               last_iter;
   logic               bad_digit;
   logic [BCD_W-1:0]   bcd_sh, bcd_adj;
   logic [BIN_W-1:0]   bin_sh;

   assign accept    = in_valid && (state_q == ST_IDLE);
   assign last_iter = (cnt_q == CNT_W'(BIN_W - 1));

   always_comb begin
      bad_digit = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
      end
   end

   // One reverse double-dabble step: shift right across both registers, then
   // undo the doubling carry (+3) in any digit that now reads 8 or more.
   always_comb begin
      {bcd_sh, bin_sh} = {bcd_sr_q, bin_sr_q} >> 1;
      bcd_adj = bcd_sh;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (bcd_sh[4*i +: 4] >= 4'd8) bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept) state_d = bad_digit ? ST_DONE : ST_CONV;
         ST_CONV: if (last_iter) state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode, from the state register only
   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
   end

   always_comb begin
      bcd_sr_d = bcd_sr_q;
      bin_sr_d = bin_sr_q;
      cnt_d    = cnt_q;
      bin_d    = bin_q;
      err_d    = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               bcd_sr_d = bcd_in;
               bin_sr_d = '0;
               cnt_d    = '0;
               if (bad_digit) begin
                  err_d = 1'b1;
                  bin_d = '0;
               end
            end
         end
         ST_CONV: begin
            bcd_sr_d = bcd_adj;
            bin_sr_d = bin_sh;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last_iter) begin
               bin_d = bin_sh;
               err_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcd_sr_q <= '0;
         bin_sr_q <= '0;
         cnt_q    <= '0;
         bin_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         bcd_sr_q <= bcd_sr_d;
         bin_sr_q <= bin_sr_d;
         cnt_q    <= cnt_d;
         bin_q    <= bin_d;
         err_q    <= err_d;
      end
   end

   assign bin_out = bin_q;
   assign err     = err_q;

endmodule
